// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative divider.
package div_pkg;

  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage : div_pkg

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU. Works on operand magnitudes for
// DATA_W iterations, then applies the sign fix and returns {rem, quo}.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    dvd_q, dvd_d;    // dividend magnitude, becomes quotient
  logic [DATA_W-1:0]    dsr_q, dsr_d;    // divisor magnitude
  logic [DATA_W-1:0]    rem_q, rem_d;    // partial remainder
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0]  result_q, result_d;
  logic                 ready_q, ready_d;

  logic [DATA_W:0]      shifted;
  logic [DATA_W:0]      diff;

  function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] v);
    return ~v + DATA_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v,
                                            input logic               is_signed);
    return (is_signed && v[DATA_W-1]) ? neg(v) : v;
  endfunction

  // One restoring step: shift in the next dividend MSB and trial-subtract.
  always_comb begin
    shifted = {rem_q, dvd_q[DATA_W-1]};
    diff    = shifted - {1'b0, dsr_q};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            cnt_d     = '0;
            dvd_d     = mag(opdata1_i, signed_div_i);
            dsr_d     = mag(opdata2_i, signed_div_i);
            rem_d     = '0;
            neg_quo_d = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_rem_d = signed_div_i && opdata1_i[DATA_W-1];
          end
        end
      end

      DivByZero: begin
        if (annul_i) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
          cnt_d    = '0;
        end else begin
          state_d  = DivEnd;
          ready_d  = DivResultReady;
          result_d = '0;
        end
      end

      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
          cnt_d    = '0;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          if (!diff[DATA_W]) begin
            rem_d = diff[DATA_W-1:0];
            dvd_d = {dvd_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = shifted[DATA_W-1:0];
            dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          result_d = {(neg_rem_q ? neg(rem_q) : rem_q),
                      (neg_quo_q ? neg(dvd_q) : dvd_q)};
          ready_d  = DivResultReady;
          state_d  = DivEnd;
        end
      end

      DivEnd: begin
        if (start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end

      default: state_d = DivFree;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule : div

// File: tb/tb_div.sv
// Directed bench for the iterative divider.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_cmp;
  int n_bad;

  div #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the start edge until ready_o is seen, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready_o && n < 60) begin
      tick();
      n++;
    end
  endtask

  // Full transaction: start, check latency and result, drop start, check idle.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [63:0] exp);
    int n;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();                          // start edge E0
    opdata1_i    = 32'hDEAD_BEEF;    // must be ignored from here on
    opdata2_i    = 32'h0000_0005;
    signed_div_i = ~sgn;
    wait_ready(n);
    expect_eq({tag, "_lat"}, 64'(n), 64'(lat));
    expect_eq({tag, "_res"}, result_o, exp);
    tick();
    expect_eq({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
    expect_eq({tag, "_hold_res"}, result_o, exp);
    start_i = 1'b0;
    tick();
    expect_eq({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
    expect_eq({tag, "_drop_res"}, result_o, 64'd0);
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();
    tick();
    expect_eq("rst_rdy", 64'(ready_o), 64'd0);
    expect_eq("rst_res", result_o, 64'd0);
    rst = 1'b0;
    tick();

    run_div("u100_7",   1'b0, 32'd100,        32'd7,          33, 64'h00000002_0000000E);
    run_div("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  33, 64'hFFFFFFFF_FFFFFFFD);
    run_div("s7_-2",    1'b1, 32'h0000_0007,  32'hFFFF_FFFE,  33, 64'h00000001_FFFFFFFD);
    run_div("dbz_u",    1'b0, 32'd1234,       32'd0,          1,  64'd0);
    run_div("dbz_s",    1'b1, 32'hFFFF_0000,  32'd0,          1,  64'd0);
    run_div("intmin",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  33, 64'h00000000_80000000);
    run_div("uffff_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          33, 64'h00000000_FFFFFFFF);
    run_div("u_big",    1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  33, 64'h00000001_00000001);

    // annul held with start in DivFree: a divide-by-zero would show ready after 2 edges
    opdata1_i = 32'd5;
    opdata2_i = 32'd0;
    start_i = 1'b1;
    annul_i = 1'b1;
    repeat (3) tick();
    expect_eq("annul_free_rdy", 64'(ready_o), 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();

    // annul during iteration 10
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    tick();
    repeat (10) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    expect_eq("annul_rdy", 64'(ready_o), 64'd0);
    expect_eq("annul_res", result_o, 64'd0);
    expect_eq("annul_cnt", 64'(dut.cnt_q), 64'd0);
    repeat (3) tick();
    expect_eq("annul_idle_rdy", 64'(ready_o), 64'd0);
    run_div("u9_3", 1'b0, 32'd9, 32'd3, 33, 64'h00000000_00000003);

    // reset at iteration 20 with start held through reset
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    tick();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    expect_eq("rst_mid_rdy", 64'(ready_o), 64'd0);
    expect_eq("rst_mid_res", result_o, 64'd0);
    expect_eq("rst_mid_cnt", 64'(dut.cnt_q), 64'd0);
    rst = 1'b0;
    tick();                          // start edge E0 from DivFree
    wait_ready(n);
    expect_eq("rst_restart_lat", 64'(n), 64'd33);
    expect_eq("rst_restart_res", result_o, 64'h00000006_0000008E);
    start_i = 1'b0;
    tick();
    expect_eq("rst_restart_drop", 64'(ready_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_div
